// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with bypass, hardwired zero register, pending scoreboard and clear engine
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_clear         request re-zeroing of every register (honoured only when ready)
//   o_ready         1 once the clear engine is idle
//   i_wr_*          NWR synchronous write ports (enable, address, data)
//   i_rd_addr       NRD read addresses; o_rd_data / o_rd_busy are combinational
//   i_sb_set/addr   mark one register as having an outstanding producer
module regfile_mp #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int NRD     = 2,
   parameter int NWR     = 2,
   parameter bit BYPASS  = 1,
   parameter bit R0_ZERO = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clear,
   output logic                o_ready,
   input  logic [NWR-1:0]      i_wr_en,
   input  logic [NWR*AW-1:0]   i_wr_addr,
   input  logic [NWR*XLEN-1:0] i_wr_data,
   input  logic [NRD*AW-1:0]   i_rd_addr,
   output logic [NRD*XLEN-1:0] o_rd_data,
   output logic [NRD-1:0]      o_rd_busy,
   input  logic                i_sb_set,
   input  logic [AW-1:0]       i_sb_addr
);
   typedef enum logic {INIT, RUN} state_t;
   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [NREG-1:0] pend_q, pend_d;
   logic [XLEN-1:0] mem [NREG];
   logic            run;
   logic [NWR-1:0]  wr_v;
   assign run     = state_q == RUN;
   assign o_ready = run;
   // A write is effective only in RUN, not in a clear cycle, and never to a hardwired zero register.
   always_comb begin
      wr_v = '0;
      for (int k = 0; k < NWR; k++)
         wr_v[k] = run && !i_clear && i_wr_en[k] && !(R0_ZERO && i_wr_addr[k*AW +: AW] == '0);
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      if (!run) begin
         cnt_d   = cnt_q + 1'b1;
         state_d = cnt_q == AW'(NREG - 1) ? RUN : INIT;
         pend_d  = '0;
      end else if (i_clear) begin
         state_d = INIT;
         cnt_d   = '0;
         pend_d  = '0;
      end else begin
         for (int k = 0; k < NWR; k++)
            if (wr_v[k]) pend_d[i_wr_addr[k*AW +: AW]] = 1'b0;
         // Set is applied last: a newly issued producer outranks an older writeback.
         if (i_sb_set && !(R0_ZERO && i_sb_addr == '0)) pend_d[i_sb_addr] = 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   // Storage is unreset so it can map onto a RAM; later ports overwrite earlier ones.
   always_ff @(posedge clk)
      if (!run) mem[cnt_q] <= '0;
      else
         for (int k = 0; k < NWR; k++)
            if (wr_v[k]) mem[i_wr_addr[k*AW +: AW]] <= i_wr_data[k*XLEN +: XLEN];
   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            b;
      assign a = i_rd_addr[p*AW +: AW];
      always_comb begin
         d = mem[a];
         b = pend_q[a];
         if (BYPASS)
            for (int k = 0; k < NWR; k++)
               if (wr_v[k] && i_wr_addr[k*AW +: AW] == a) begin
                  d = i_wr_data[k*XLEN +: XLEN];
                  b = 1'b0;
               end
         if (!run || (R0_ZERO && a == '0)) begin
            d = '0;
            b = 1'b0;
         end
      end
      assign o_rd_data[p*XLEN +: XLEN] = d;
      assign o_rd_busy[p]              = b;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the rv32i core and its successors. It provides NRD combinational read ports and NWR synchronous write ports, with optional same-cycle write-to-read bypass and a hardwired zero register. It adds a per-register pending scoreboard for hazard detection. Storage has no flop reset, so it can map to RAM/latch arrays; it is zeroed instead by a sequential clear engine after reset or on request. It sits between decode (reads, scoreboard set) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports
NWR, 2, number of write ports (>=1)
BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored value
R0_ZERO, 1, 1 = register 0 reads 0, ignores writes, never pending
AW, $clog2(NREG), derived address width (localparam, not overridable)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
i_clear  input  1  request re-zeroing of all registers
o_ready  output  1  1 = clear engine idle, file usable
i_wr_en  input  NWR  per-port write enable
i_wr_addr  input  NWR*AW  write addresses, port k at bits [k*AW +: AW]
i_wr_data  input  NWR*XLEN  write data, port k at bits [k*XLEN +: XLEN]
i_rd_addr  input  NRD*AW  read addresses
o_rd_data  output  NRD*XLEN  read data, combinational
o_rd_busy  output  NRD  read register has an outstanding producer
i_sb_set  input  1  mark register i_sb_addr pending
i_sb_addr  input  AW  scoreboard set address

Behaviour:
- FSM states INIT and RUN.
- On rst: state=INIT, counter=0, all pending bits=0, o_ready=0. Storage contents are not reset.
- INIT: each cycle writes 0 to reg[counter], then counter++. After the write of NREG-1, go to RUN on the next edge, so o_ready=1 exactly NREG cycles after rst deasserts.
- During INIT: i_wr_en and i_sb_set are ignored, o_rd_data=0, o_rd_busy=0.
- RUN: o_ready=1. If i_clear=1 at an edge, go to INIT with counter=0 and clear all pending bits; port writes in that same cycle are dropped.
- i_clear during INIT is ignored (no restart).
- rst asserted mid-INIT or mid-RUN restarts INIT immediately.
- Writes: at posedge, each port with i_wr_en=1 writes its data.
  - Several ports to the same address: the highest-index port wins.
  - Address 0 with R0_ZERO=1: write dropped.
- Reads, per port:
  - addr 0 with R0_ZERO=1 -> 0.
  - Else if BYPASS=1 and any enabled write port matches -> data of the highest-index matching port.
  - Else -> stored value.
  - Zero read latency.
- Scoreboard:
  - pending[a] is set at the edge when i_sb_set=1 and a=i_sb_addr.
  - pending[a] is cleared at the edge when any enabled write port targets a.
  - Set and write to the same address in one cycle: set wins, because the new producer is issued after the older writeback.
  - Address 0 with R0_ZERO=1 is never set.
- o_rd_busy[p] = pending[addr_p], except it is 0 if BYPASS=1 and a same-cycle enabled write targets addr_p. With BYPASS=0, busy stays 1 in the write cycle.
- No X propagation: every output is defined in every state.

Test Plan:
- Reset/init: pulse rst, NREG=32 -> o_ready=0 for 32 cycles, 1 on cycle 32. All 32 registers read 0. Writes issued during INIT leave the registers at 0.
- Write/read and r0: write 0xDEADBEEF to x5 via port0 and 0x12345678 to x0 -> next cycle x5=0xDEADBEEF, x0=0.
- Port conflict plus bypass: port0 writes x7=0x1, port1 writes x7=0x2 in the same cycle. BYPASS=1 -> same-cycle read of x7 = 0x2, stored value = 0x2. Repeat with BYPASS=0 -> same-cycle read shows the old value, next cycle 0x2.
- Scoreboard: set x9 -> o_rd_busy=1 on a read of x9. A write to x9 alongside a new set of x9 -> still busy. A write alone -> busy clears, with bypass showing busy=0 in the write cycle itself.
- Soft clear: after filling x1..x31 with nonzero data and setting x3 pending, assert i_clear for 1 cycle -> o_ready=0 for 32 cycles, x3 not busy, all registers read 0. A second i_clear during INIT does not extend the count.
- Async reset mid-INIT: assert rst at counter=10 -> o_ready stays 0 and the count restarts from 0, giving 32 more cycles.
